// File: rtl/player_hand.sv
`default_nettype none
// ============================================================================
// Module   : player_hand
// Purpose  : Card-hand storage for one player. Handles deck draws, legality
//            checks for plays, and compaction of the hand after a play.
// Revision : 1.0 - initial release
// ============================================================================
module player_hand #(
    parameter int MAX_CARDS = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_clear,
    input  logic [2:0] i_draw_req,
    input  logic       i_play,
    input  logic [4:0] i_play_idx,
    input  logic [5:0] i_top_card,
    input  logic       i_deck_ready,
    input  logic       i_deck_drawn,
    input  logic [5:0] i_deck_card,
    input  logic [4:0] i_view_idx,
    output logic [2:0] o_deck_draw,
    output logic       o_insert,
    output logic [5:0] o_insert_card,
    output logic [5:0] o_view_card,
    output logic [5:0] o_count,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_illegal,
    output logic       o_uno
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRAW   = 3'd1,
        S_CHECK  = 3'd2,
        S_INSERT = 3'd3,
        S_SHIFT  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [5:0] c_empty   = 6'h3F;
    localparam logic [5:0] c_max_cnt = 6'(MAX_CARDS);

    state_t     state_q, state_d;
    logic [5:0] hand_q [MAX_CARDS];
    logic [5:0] hand_d [MAX_CARDS];
    logic [5:0] count_q, count_d;
    logic [5:0] ptr_q, ptr_d;
    logic [2:0] rem_q, rem_d;
    logic [2:0] draw_q, draw_d;
    logic       illegal_q, illegal_d;

    logic [5:0] w_cur_card;
    logic [5:0] w_next_card;
    logic [5:0] w_view_card;
    logic       w_legal;

    // Slot reads by comparison so no index ever falls outside the array
    always_comb begin
        w_cur_card  = c_empty;
        w_next_card = c_empty;
        w_view_card = c_empty;
        for (int i = 0; i < MAX_CARDS; i++) begin
            if (6'(i) == ptr_q)              w_cur_card  = hand_q[i];
            if (6'(i) == ptr_q + 6'd1)       w_next_card = hand_q[i];
            if (6'(i) == {1'b0, i_view_idx}) w_view_card = hand_q[i];
        end
        if ({1'b0, i_view_idx} >= count_q) w_view_card = c_empty;
    end

    assign w_legal = (w_cur_card[5:4] == i_top_card[5:4]) ||
                     (w_cur_card[3:0] == i_top_card[3:0]) ||
                     (w_cur_card[3:0] >= 4'd13);

    always_comb begin
        state_d   = state_q;
        hand_d    = hand_q;
        count_d   = count_q;
        ptr_d     = ptr_q;
        rem_d     = rem_q;
        draw_d    = draw_q;
        illegal_d = 1'b0;

        if (i_clear) begin
            for (int i = 0; i < MAX_CARDS; i++) hand_d[i] = c_empty;
            count_d = 6'd0;
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_draw_req != 3'b000) begin
                        if (count_q == c_max_cnt) begin
                            illegal_d = 1'b1;
                        end else begin
                            state_d = S_DRAW;
                            if (i_draw_req[2]) begin
                                draw_d = 3'b100;
                                rem_d  = 3'd4;
                            end else if (i_draw_req[1]) begin
                                draw_d = 3'b010;
                                rem_d  = 3'd2;
                            end else begin
                                draw_d = 3'b001;
                                rem_d  = 3'd1;
                            end
                        end
                    end else if (i_play) begin
                        if ({1'b0, i_play_idx} >= count_q) begin
                            illegal_d = 1'b1;
                        end else begin
                            ptr_d   = {1'b0, i_play_idx};
                            state_d = S_CHECK;
                        end
                    end
                end
                S_DRAW: begin
                    if (i_deck_drawn) begin
                        for (int i = 0; i < MAX_CARDS; i++) begin
                            if (6'(i) == count_q) hand_d[i] = i_deck_card;
                        end
                        count_d = count_q + 6'd1;
                        rem_d   = rem_q - 3'd1;
                        if (rem_q == 3'd1 || count_q + 6'd1 == c_max_cnt) state_d = S_DONE;
                    end
                end
                S_CHECK: begin
                    if (w_legal) begin
                        state_d = S_INSERT;
                    end else begin
                        illegal_d = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
                S_INSERT: begin
                    if (i_deck_ready) state_d = S_SHIFT;
                end
                S_SHIFT: begin
                    // Pull the next card down; the last occupied slot is emptied
                    for (int i = 0; i < MAX_CARDS; i++) begin
                        if (6'(i) == ptr_q) begin
                            hand_d[i] = (ptr_q == count_q - 6'd1) ? c_empty : w_next_card;
                        end
                    end
                    if (ptr_q == count_q - 6'd1) begin
                        count_d = count_q - 6'd1;
                        state_d = S_DONE;
                    end else begin
                        ptr_d = ptr_q + 6'd1;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            for (int i = 0; i < MAX_CARDS; i++) hand_q[i] <= c_empty;
            count_q   <= 6'd0;
            ptr_q     <= 6'd0;
            rem_q     <= 3'd0;
            draw_q    <= 3'b000;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hand_q    <= hand_d;
            count_q   <= count_d;
            ptr_q     <= ptr_d;
            rem_q     <= rem_d;
            draw_q    <= draw_d;
            illegal_q <= illegal_d;
        end
    end

    assign o_deck_draw   = (state_q == S_DRAW && !i_clear) ? draw_q : 3'b000;
    assign o_insert      = (state_q == S_INSERT) && i_deck_ready && !i_clear;
    assign o_insert_card = o_insert ? w_cur_card : 6'h00;
    assign o_view_card   = w_view_card;
    assign o_count       = count_q;
    assign o_busy        = (state_q != S_IDLE);
    assign o_done        = (state_q == S_DONE) && !i_clear;
    assign o_illegal     = illegal_q && !i_clear;
    assign o_uno         = (count_q == 6'd1);

endmodule
`default_nettype wire

// File: tb/tb_player_hand.sv
`default_nettype none
// ============================================================================
// Module   : tb_player_hand
// Purpose  : Randomized self-checking bench for player_hand against a
//            queue-based hand model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_player_hand;

    localparam int MAX = 16;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_clear = 1'b0;
    logic [2:0] i_draw_req = 3'b000;
    logic       i_play = 1'b0;
    logic [4:0] i_play_idx = 5'd0;
    logic [5:0] i_top_card = 6'd0;
    logic       i_deck_ready = 1'b1;
    logic       i_deck_drawn = 1'b0;
    logic [5:0] i_deck_card = 6'd0;
    logic [4:0] i_view_idx = 5'd0;
    logic [2:0] o_deck_draw;
    logic       o_insert;
    logic [5:0] o_insert_card;
    logic [5:0] o_view_card;
    logic [5:0] o_count;
    logic       o_busy;
    logic       o_done;
    logic       o_illegal;
    logic       o_uno;

    player_hand #(.MAX_CARDS(MAX)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clear(i_clear),
        .i_draw_req(i_draw_req), .i_play(i_play), .i_play_idx(i_play_idx),
        .i_top_card(i_top_card), .i_deck_ready(i_deck_ready),
        .i_deck_drawn(i_deck_drawn), .i_deck_card(i_deck_card),
        .i_view_idx(i_view_idx), .o_deck_draw(o_deck_draw), .o_insert(o_insert),
        .o_insert_card(o_insert_card), .o_view_card(o_view_card),
        .o_count(o_count), .o_busy(o_busy), .o_done(o_done),
        .o_illegal(o_illegal), .o_uno(o_uno)
    );

    always #5 i_clk = ~i_clk;

    int n_chk  = 0;
    int n_fail = 0;
    logic [5:0] hand_m [$];
    logic [5:0] deck_q [$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_hand();
        chk("count", 32'(o_count), 32'(hand_m.size()));
        chk("uno", 32'(o_uno), 32'(hand_m.size() == 1));
        chk("busy_idle", 32'(o_busy), 0);
        for (int i = 0; i < MAX + 2; i++) begin
            i_view_idx = 5'(i);
            @(negedge i_clk);
            chk($sformatf("view[%0d]", i), 32'(o_view_card),
                32'((i < hand_m.size()) ? hand_m[i] : 6'h3F));
        end
    endtask

    task automatic do_clear();
        i_clear = 1'b1;
        step();
        i_clear = 1'b0;
        hand_m.delete();
        chk("clear_count", 32'(o_count), 0);
    endtask

    task automatic do_draw(input logic [2:0] req);
        int n, k;
        logic [2:0] dec;
        logic [5:0] card;
        n   = req[2] ? 4 : (req[1] ? 2 : 1);
        dec = req[2] ? 3'b100 : (req[1] ? 3'b010 : 3'b001);
        i_draw_req = req;
        step();
        i_draw_req = 3'b000;
        if (hand_m.size() == MAX) begin
            chk("draw_full_illegal", 32'(o_illegal), 1);
            chk("draw_full_busy", 32'(o_busy), 0);
            step();
            chk("draw_full_pulse", 32'(o_illegal), 0);
            return;
        end
        chk("draw_busy", 32'(o_busy), 1);
        chk("draw_req", 32'(o_deck_draw), 32'(dec));
        k = (n < MAX - hand_m.size()) ? n : MAX - hand_m.size();
        for (int j = 0; j < k; j++) begin
            repeat ($urandom_range(0, 2)) begin
                i_play     = 1'b1;
                i_draw_req = 3'($urandom);
                step();
                chk("draw_hold", 32'(o_deck_draw), 32'(dec));
            end
            i_play     = 1'b0;
            i_draw_req = 3'b000;
            card = (deck_q.size() > 0) ? deck_q.pop_front() : 6'($urandom_range(0, 62));
            i_deck_card  = card;
            i_deck_drawn = 1'b1;
            step();
            i_deck_drawn = 1'b0;
            hand_m.push_back(card);
            if (j < k - 1) chk("draw_hold_pulse", 32'(o_deck_draw), 32'(dec));
        end
        chk("draw_done", 32'(o_done), 1);
        chk("draw_req_off", 32'(o_deck_draw), 0);
        chk("draw_no_illegal", 32'(o_illegal), 0);
        step();
        chk("draw_done_pulse", 32'(o_done), 0);
        chk("draw_idle", 32'(o_busy), 0);
    endtask

    task automatic do_play(input int idx, input int w, input logic [5:0] top);
        logic [5:0] card;
        logic       legal;
        int         lat;
        int         s;
        i_top_card   = top;
        i_deck_ready = (w == 0);
        i_play       = 1'b1;
        i_play_idx   = 5'(idx);
        step();
        i_play = 1'b0;
        if (idx >= hand_m.size()) begin
            chk("play_idx_illegal", 32'(o_illegal), 1);
            chk("play_idx_busy", 32'(o_busy), 0);
            step();
            chk("play_idx_pulse", 32'(o_illegal), 0);
            i_deck_ready = 1'b1;
            return;
        end
        chk("play_check_busy", 32'(o_busy), 1);
        card  = hand_m[idx];
        legal = (card[5:4] == top[5:4]) || (card[3:0] == top[3:0]) || (card[3:0] >= 4'd13);
        step();
        if (!legal) begin
            chk("play_rule_illegal", 32'(o_illegal), 1);
            chk("play_rule_busy", 32'(o_busy), 0);
            i_deck_ready = 1'b1;
            step();
            chk("play_rule_pulse", 32'(o_illegal), 0);
            return;
        end
        chk("play_legal_noill", 32'(o_illegal), 0);
        for (int j = 0; j < w; j++) begin
            chk("insert_wait", 32'(o_insert), 0);
            chk("insert_wait_card", 32'(o_insert_card), 0);
            step();
        end
        i_deck_ready = 1'b1;
        #1;
        chk("insert", 32'(o_insert), 1);
        chk("insert_card", 32'(o_insert_card), 32'(card));
        step();
        chk("insert_pulse", 32'(o_insert), 0);
        s   = hand_m.size() - idx;
        lat = 2 + w;
        while (!o_done && lat < 200) begin
            step();
            lat++;
        end
        chk("play_latency", 32'(lat), 32'(2 + w + s));
        hand_m.delete(idx);
        chk("play_count", 32'(o_count), 32'(hand_m.size()));
        step();
        chk("play_done_pulse", 32'(o_done), 0);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_count", 32'(o_count), 0);
        chk("rst_outs", 32'({o_deck_draw, o_insert, o_insert_card, o_busy, o_done, o_illegal, o_uno}), 0);
        chk("rst_view", 32'(o_view_card), 32'h3F);
        step();
        i_rst_n = 1'b1;
        step();
        check_hand();

        // Four-card draw with fixed cards
        deck_q = '{6'h00, 6'h15, 6'h2C, 6'h3E};
        do_draw(3'b100);
        check_hand();

        // Play from a three-card hand
        do_clear();
        deck_q = '{6'h01, 6'h12, 6'h23};
        do_draw(3'b010);
        do_draw(3'b001);
        do_play(0, 0, 6'h13);
        check_hand();

        // Illegal card and illegal index
        do_clear();
        deck_q = '{6'h01};
        do_draw(3'b001);
        do_play(0, 0, 6'h2A);
        do_play(3, 0, 6'h2A);
        check_hand();

        // Wild card with a stalled deck
        do_clear();
        deck_q = '{6'h0D};
        do_draw(3'b001);
        do_play(0, 3, 6'h35);
        check_hand();

        // Capacity truncation then full-hand rejection
        do_clear();
        do_draw(3'b100); do_draw(3'b100); do_draw(3'b100);
        do_draw(3'b010); do_draw(3'b001);
        do_draw(3'b010);
        do_draw(3'b001);
        check_hand();

        // Clear mid-draw
        do_clear();
        i_draw_req = 3'b010;
        step();
        i_draw_req = 3'b000;
        i_deck_card  = 6'h22;
        i_deck_drawn = 1'b1;
        step();
        i_deck_drawn = 1'b0;
        i_clear = 1'b1;
        step();
        i_clear = 1'b0;
        chk("clr_count", 32'(o_count), 0);
        chk("clr_draw", 32'(o_deck_draw), 0);
        chk("clr_done", 32'(o_done), 0);
        chk("clr_busy", 32'(o_busy), 0);
        step();
        chk("clr_quiet", 32'({o_done, o_illegal}), 0);

        // Reset mid-draw
        i_draw_req = 3'b100;
        step();
        i_draw_req   = 3'b000;
        i_deck_card  = 6'h11;
        i_deck_drawn = 1'b1;
        step();
        i_deck_drawn = 1'b0;
        i_view_idx   = 5'd0;
        i_rst_n      = 1'b0;
        #1;
        chk("mrst_count", 32'(o_count), 0);
        chk("mrst_outs", 32'({o_deck_draw, o_busy, o_done, o_illegal, o_uno}), 0);
        chk("mrst_view", 32'(o_view_card), 32'h3F);
        step();
        i_rst_n = 1'b1;
        repeat (3) begin
            step();
            chk("mrst_quiet", 32'({o_done, o_illegal, o_busy}), 0);
        end
        hand_m.delete();

        // Stray deck pulse while idle
        i_deck_card  = 6'h05;
        i_deck_drawn = 1'b1;
        step();
        i_deck_drawn = 1'b0;
        chk("stray_drawn", 32'(o_count), 0);

        // Randomized operations
        for (int it = 0; it < 80; it++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op < 4) begin
                logic [2:0] r;
                r = 3'($urandom_range(1, 7));
                do_draw(r);
            end else if (op < 9) begin
                do_play($urandom_range(0, hand_m.size() + 1), $urandom_range(0, 3),
                        6'($urandom_range(0, 63)));
            end else begin
                do_clear();
            end
            if (it % 10 == 9) check_hand();
        end
        check_hand();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
